multicycle_control_unit: RTL and testbench

//  Multi-cycle MIPS-subset controller: FSM sequences fetch/decode/execute/mem/writeback.

---
 rtl/mcu_pkg.sv | 75 +++++++
 rtl/mcu_alu_decoder.sv | 31 +++
 rtl/multicycle_control_unit.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, functs,
// state codes, ALU op codes and datapath mux selects.
package mcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOR = 3'd5;
    localparam logic [2:0] ALU_SLT = 3'd6;

    localparam logic [1:0] ASB_B      = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_JUMP   = 4'd11,
        ST_TRAP   = 4'd15
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       trap;
    } ctl_t;

    // States that wait on mem_ready and run the wait counter.
    function automatic logic is_mem_state(state_e s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/mcu_alu_decoder.sv
// R-type funct to ALU control decode; unlisted functs report funct_valid=0.
module mcu_alu_decoder
    import mcu_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic [5:0]            funct,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  funct_valid
);

    logic [2:0] op;

    always_comb begin
        op          = ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_XOR:  op = ALU_XOR;
            FN_NOR:  op = ALU_NOR;
            FN_SLT:  op = ALU_SLT;
            default: funct_valid = 1'b0;
        endcase
    end

    assign alu_control = ALU_CTRL_W'(op);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS-subset controller with memory wait/timeout and illegal-op trap.
// Define MCU_JUMP_EN to support the j instruction; otherwise opcode 000010 traps.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  pc_write_cond,
    output logic                  iord,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  instr_done,
    output logic                  trap,
    output logic [3:0]            state_out
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e                state, nxt;
    logic [7:0]            wait_cnt;
    ctl_t                  ctl, ctl_q;
    logic [ALU_CTRL_W-1:0] alu_c;
    logic [ALU_CTRL_W-1:0] dec_alu;
    logic                  funct_valid;
    logic                  stall_to;

    // The datapath qualifies pc_write_cond with zero itself.
    logic unused_zero;
    assign unused_zero = zero;

    mcu_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
        .funct       (funct),
        .alu_control (dec_alu),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= nxt;
    end

    // Counts stall cycles in a memory state; any non-stall cycle clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  wait_cnt <= '0;
        else if (is_mem_state(state) && !mem_ready)  wait_cnt <= wait_cnt + 8'd1;
        else                                         wait_cnt <= '0;
    end

    assign stall_to = (wait_cnt == WAIT_LAST);

    always_comb begin
        nxt   = state;
        ctl   = '0;
        alu_c = ALU_CTRL_W'(ALU_ADD);
        case (state)
            ST_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = ASB_FOUR;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    nxt          = ST_DECODE;
                end else if (stall_to) begin
                    nxt = ST_TRAP;
                end
            end
            ST_DECODE: begin
                ctl.alu_src_b = ASB_IMM_SH;
                case (opcode)
                    OP_RTYPE:     nxt = ST_EXEC;
                    OP_LW, OP_SW: nxt = ST_MEMADR;
                    OP_BEQ:       nxt = ST_BRANCH;
                    OP_ADDI:      nxt = ST_ADDIEX;
`ifdef MCU_JUMP_EN
                    OP_J:         nxt = ST_JUMP;
`endif
                    default:      nxt = ST_TRAP;
                endcase
            end
            ST_MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ASB_IMM;
                nxt           = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                ctl.iord     = 1'b1;
                ctl.mem_read = 1'b1;
                if (mem_ready)     nxt = ST_MEMWB;
                else if (stall_to) nxt = ST_TRAP;
            end
            ST_MEMWB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                nxt            = ST_FETCH;
            end
            ST_MEMWR: begin
                ctl.iord      = 1'b1;
                ctl.mem_write = 1'b1;
                if (mem_ready) begin
                    ctl.instr_done = 1'b1;
                    nxt            = ST_FETCH;
                end else if (stall_to) begin
                    nxt = ST_TRAP;
                end
            end
            ST_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ASB_B;
                alu_c         = dec_alu;
                nxt           = funct_valid ? ST_ALUWB : ST_TRAP;
            end
            ST_ALUWB: begin
                ctl.reg_dst    = 1'b1;
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                nxt            = ST_FETCH;
            end
            ST_BRANCH: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = ASB_B;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_src        = PCS_ALUOUT;
                ctl.instr_done    = 1'b1;
                alu_c             = ALU_CTRL_W'(ALU_SUB);
                nxt               = ST_FETCH;
            end
            ST_ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = ASB_IMM;
                nxt           = ST_ADDIWB;
            end
            ST_ADDIWB: begin
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                nxt            = ST_FETCH;
            end
`ifdef MCU_JUMP_EN
            ST_JUMP: begin
                ctl.pc_src     = PCS_JUMP;
                ctl.pc_write   = 1'b1;
                ctl.instr_done = 1'b1;
                nxt            = ST_FETCH;
            end
`endif
            ST_TRAP: begin
                ctl.trap = 1'b1;
            end
            default: nxt = ST_TRAP;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, even though state is FETCH.
    assign ctl_q         = rst_n ? ctl : '0;
    assign pc_write      = ctl_q.pc_write;
    assign pc_write_cond = ctl_q.pc_write_cond;
    assign iord          = ctl_q.iord;
    assign mem_read      = ctl_q.mem_read;
    assign mem_write     = ctl_q.mem_write;
    assign ir_write      = ctl_q.ir_write;
    assign reg_dst       = ctl_q.reg_dst;
    assign mem_to_reg    = ctl_q.mem_to_reg;
    assign reg_write     = ctl_q.reg_write;
    assign alu_src_a     = ctl_q.alu_src_a;
    assign alu_src_b     = ctl_q.alu_src_b;
    assign pc_src        = ctl_q.pc_src;
    assign instr_done    = ctl_q.instr_done;
    assign trap          = ctl_q.trap;
    assign alu_control   = rst_n ? alu_c : '0;
    assign state_out     = rst_n ? state : 4'd0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit (MEM_TIMEOUT=4); follows MCU_JUMP_EN.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, trap;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state_out;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .alu_control(alu_control), .instr_done(instr_done), .trap(trap),
        .state_out(state_out)
    );

    // {pw pwc iord mr mw irw} {rd m2r rw} {asa asb pcs} {alu} {done trap}
    wire [18:0] ctl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
                       alu_control, instr_done, trap};

    localparam logic [18:0] C_FTCH  = {6'b100101, 3'b000, 5'b00100, 3'd0, 2'b00};
    localparam logic [18:0] C_FSTL  = {6'b000100, 3'b000, 5'b00100, 3'd0, 2'b00};
    localparam logic [18:0] C_DEC   = {6'b000000, 3'b000, 5'b01100, 3'd0, 2'b00};
    localparam logic [18:0] C_MADR  = {6'b000000, 3'b000, 5'b11000, 3'd0, 2'b00};
    localparam logic [18:0] C_MRD   = {6'b001100, 3'b000, 5'b00000, 3'd0, 2'b00};
    localparam logic [18:0] C_MWB   = {6'b000000, 3'b011, 5'b00000, 3'd0, 2'b10};
    localparam logic [18:0] C_MWR   = {6'b001010, 3'b000, 5'b00000, 3'd0, 2'b00};
    localparam logic [18:0] C_MWRD  = {6'b001010, 3'b000, 5'b00000, 3'd0, 2'b10};
    localparam logic [18:0] C_ALUWB = {6'b000000, 3'b101, 5'b00000, 3'd0, 2'b10};
    localparam logic [18:0] C_BR    = {6'b010000, 3'b000, 5'b10001, 3'd1, 2'b10};
    localparam logic [18:0] C_AIEX  = {6'b000000, 3'b000, 5'b11000, 3'd0, 2'b00};
    localparam logic [18:0] C_AIWB  = {6'b000000, 3'b001, 5'b00000, 3'd0, 2'b10};
    localparam logic [18:0] C_JMP   = {6'b100000, 3'b000, 5'b00010, 3'd0, 2'b10};
    localparam logic [18:0] C_TRAP  = {6'b000000, 3'b000, 5'b00000, 3'd0, 2'b01};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive mem_ready for one cycle, check state and control word, advance.
    task automatic cyc(input string tag, input logic rdy, input logic [3:0] st, input logic [18:0] c);
        mem_ready = rdy;
        #1;
        chk({tag, ".state"}, 32'(state_out), 32'(st));
        chk({tag, ".ctl"}, 32'(ctl), 32'(c));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".rst_ctl"}, 32'(ctl), 32'd0);
        chk({tag, ".rst_state"}, 32'(state_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [5:0] fn_tab [6] = '{6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};

    initial begin
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset("init");

        // add: 4 cycles, mem_ready ignored outside memory states
        opcode = 6'b000000; funct = 6'b100000;
        cyc("add.f", 1'b1, 4'd0, C_FTCH);
        cyc("add.d", 1'b0, 4'd1, C_DEC);
        cyc("add.x", 1'b0, 4'd6, {6'b0, 3'b000, 5'b10000, 3'd0, 2'b00});
        cyc("add.wb", 1'b0, 4'd7, C_ALUWB);

        // other R-types: ALU code per funct
        for (int i = 0; i < 6; i++) begin
            funct = fn_tab[i];
            cyc("r.f", 1'b1, 4'd0, C_FTCH);
            cyc("r.d", 1'b1, 4'd1, C_DEC);
            cyc($sformatf("r%0d.x", i + 1), 1'b1, 4'd6, {6'b0, 3'b000, 5'b10000, 3'(i + 1), 2'b00});
            cyc("r.wb", 1'b1, 4'd7, C_ALUWB);
        end

        // lw with 3 stall cycles in MEMRD: 8 cycles
        opcode = 6'b100011;
        cyc("lw.f", 1'b1, 4'd0, C_FTCH);
        cyc("lw.d", 1'b1, 4'd1, C_DEC);
        cyc("lw.a", 1'b1, 4'd2, C_MADR);
        cyc("lw.r0", 1'b0, 4'd3, C_MRD);
        cyc("lw.r1", 1'b0, 4'd3, C_MRD);
        cyc("lw.r2", 1'b0, 4'd3, C_MRD);
        cyc("lw.r3", 1'b1, 4'd3, C_MRD);
        cyc("lw.wb", 1'b0, 4'd4, C_MWB);

        // sw with one stall; done only on the ready cycle
        opcode = 6'b101011;
        cyc("sw.f", 1'b1, 4'd0, C_FTCH);
        cyc("sw.d", 1'b1, 4'd1, C_DEC);
        cyc("sw.a", 1'b1, 4'd2, C_MADR);
        cyc("sw.w0", 1'b0, 4'd5, C_MWR);
        cyc("sw.w1", 1'b1, 4'd5, C_MWRD);

        // beq, zero=1: 3 cycles
        opcode = 6'b000100; zero = 1'b1;
        cyc("beq.f", 1'b1, 4'd0, C_FTCH);
        cyc("beq.d", 1'b1, 4'd1, C_DEC);
        cyc("beq.b", 1'b1, 4'd8, C_BR);

        // addi: 4 cycles
        opcode = 6'b001000; zero = 1'b0;
        cyc("addi.f", 1'b1, 4'd0, C_FTCH);
        cyc("addi.d", 1'b1, 4'd1, C_DEC);
        cyc("addi.x", 1'b1, 4'd9, C_AIEX);
        cyc("addi.wb", 1'b1, 4'd10, C_AIWB);

        // jump: taken with the macro, trap otherwise
        opcode = 6'b000010;
        cyc("j.f", 1'b1, 4'd0, C_FTCH);
        cyc("j.d", 1'b1, 4'd1, C_DEC);
`ifdef MCU_JUMP_EN
        cyc("j.j", 1'b1, 4'd11, C_JMP);
        cyc("j.next", 1'b1, 4'd0, C_FTCH);
`else
        cyc("j.trap", 1'b1, 4'd15, C_TRAP);
`endif
        do_reset("j");

        // illegal opcode: trap after DECODE, sticky
        opcode = 6'b111111;
        cyc("ill.f", 1'b1, 4'd0, C_FTCH);
        cyc("ill.d", 1'b1, 4'd1, C_DEC);
        cyc("ill.t0", 1'b1, 4'd15, C_TRAP);
        cyc("ill.t1", 1'b0, 4'd15, C_TRAP);
        do_reset("ill");
        cyc("ill.post", 1'b1, 4'd0, C_FTCH);

        // illegal funct: trap from EXEC without ALUWB
        opcode = 6'b000000; funct = 6'b000000;
        cyc("ilf.d", 1'b1, 4'd1, C_DEC);
        cyc("ilf.x", 1'b1, 4'd6, {6'b0, 3'b000, 5'b10000, 3'd0, 2'b00});
        cyc("ilf.t", 1'b1, 4'd15, C_TRAP);
        do_reset("ilf");

        // fetch timeout: 4 stall cycles then trap
        cyc("fto.s0", 1'b0, 4'd0, C_FSTL);
        cyc("fto.s1", 1'b0, 4'd0, C_FSTL);
        cyc("fto.s2", 1'b0, 4'd0, C_FSTL);
        cyc("fto.s3", 1'b0, 4'd0, C_FSTL);
        cyc("fto.t0", 1'b1, 4'd15, C_TRAP);
        cyc("fto.t1", 1'b1, 4'd15, C_TRAP);
        do_reset("fto");
        cyc("fto.post", 1'b1, 4'd0, C_FTCH);

        // MEMRD timeout, then reset aborting a pending MEMWR access
        opcode = 6'b100011;
        cyc("rto.d", 1'b1, 4'd1, C_DEC);
        cyc("rto.a", 1'b1, 4'd2, C_MADR);
        cyc("rto.s0", 1'b0, 4'd3, C_MRD);
        cyc("rto.s1", 1'b0, 4'd3, C_MRD);
        cyc("rto.s2", 1'b0, 4'd3, C_MRD);
        cyc("rto.s3", 1'b0, 4'd3, C_MRD);
        cyc("rto.t", 1'b0, 4'd15, C_TRAP);
        do_reset("rto");
        opcode = 6'b101011;
        cyc("abt.f", 1'b1, 4'd0, C_FTCH);
        cyc("abt.d", 1'b1, 4'd1, C_DEC);
        cyc("abt.a", 1'b1, 4'd2, C_MADR);
        cyc("abt.w", 1'b0, 4'd5, C_MWR);
        do_reset("abt");
        cyc("abt.post", 1'b0, 4'd0, C_FSTL);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
